// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: up to PUSH_N entries in and POP_N entries out per cycle, in program order.
// Define FDQ_BYPASS_EN to forward fetch slots straight to decode when the queue is empty.
module fetch_decode_queue #(
    parameter int DEPTH  = 8,
    parameter int PUSH_N = 2,
    parameter int POP_N  = 2,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flushD,
    input  logic                       stallD,
    input  logic [PUSH_N-1:0]          in_valid,
    input  logic [PUSH_N*ADDR_W-1:0]   in_pc,
    input  logic [PUSH_N*ADDR_W-1:0]   in_instr,
    input  logic [PUSH_N-1:0]          in_dslot,
    output logic                       in_ready,
    output logic [POP_N-1:0]           out_valid,
    output logic [POP_N*ADDR_W-1:0]    out_pc,
    output logic [POP_N*ADDR_W-1:0]    out_instr,
    output logic [POP_N-1:0]           out_dslot,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_mem    [DEPTH];
    logic [ADDR_W-1:0] instr_mem [DEPTH];
    logic [DEPTH-1:0]  dslot_mem;

    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  push_n, pop_n, store_n;
    logic [CNT_W-1:0]  byp_n, byp_vis_n;
    logic              push_en;
    logic [PUSH_N-1:0] wr_en;
    logic [PTR_W-1:0]  wr_idx [PUSH_N];

    // Only the leading run of valid slots counts; anything after a gap is dropped.
    always_comb begin
        logic run;
        run    = 1'b1;
        push_n = '0;
        for (int i = 0; i < PUSH_N; i++) begin
            run = run & in_valid[i];
            if (run) push_n = push_n + CNT_W'(1);
        end
    end

    assign in_ready = (count <= CNT_W'(DEPTH - PUSH_N));
    assign push_en  = in_ready & ~flushD;

    always_comb begin
        if (stallD | flushD)
            pop_n = '0;
        else if (count < CNT_W'(POP_N))
            pop_n = count;
        else
            pop_n = CNT_W'(POP_N);
    end

`ifdef FDQ_BYPASS_EN
    // An empty queue forwards the leading fetch slots; consumed ones are never stored.
    always_comb begin
        byp_vis_n = '0;
        if ((count == '0) && !flushD)
            byp_vis_n = (push_n < CNT_W'(POP_N)) ? push_n : CNT_W'(POP_N);
        byp_n = stallD ? '0 : byp_vis_n;
    end
`else
    assign byp_vis_n = '0;
    assign byp_n     = '0;
`endif

    assign store_n = push_en ? (push_n - byp_n) : '0;

    always_comb begin
        for (int i = 0; i < PUSH_N; i++) begin
            wr_en[i]  = push_en && (CNT_W'(i) >= byp_n) && (CNT_W'(i) < push_n);
            wr_idx[i] = wr_ptr + PTR_W'(i) - byp_n[PTR_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_N; i++) begin
            if (wr_en[i]) begin
                pc_mem[wr_idx[i]]    <= in_pc[i*ADDR_W +: ADDR_W];
                instr_mem[wr_idx[i]] <= in_instr[i*ADDR_W +: ADDR_W];
                dslot_mem[wr_idx[i]] <= in_dslot[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flushD) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + pop_n[PTR_W-1:0];
            wr_ptr <= wr_ptr + store_n[PTR_W-1:0];
            count  <= count + store_n - pop_n;
        end
    end

    // Invalid head slots read as zero so decode sees the same bubble as a cleared F/D register.
    always_comb begin
        out_valid = '0;
        out_pc    = '0;
        out_instr = '0;
        out_dslot = '0;
        for (int j = 0; j < POP_N; j++) begin
            if (CNT_W'(j) < count) begin
                out_valid[j]                  = 1'b1;
                out_pc[j*ADDR_W +: ADDR_W]    = pc_mem[rd_ptr + PTR_W'(j)];
                out_instr[j*ADDR_W +: ADDR_W] = instr_mem[rd_ptr + PTR_W'(j)];
                out_dslot[j]                  = dslot_mem[rd_ptr + PTR_W'(j)];
            end
            if (CNT_W'(j) < byp_vis_n) begin
                out_valid[j]                  = 1'b1;
                out_pc[j*ADDR_W +: ADDR_W]    = in_pc[(j % PUSH_N)*ADDR_W +: ADDR_W];
                out_instr[j*ADDR_W +: ADDR_W] = in_instr[(j % PUSH_N)*ADDR_W +: ADDR_W];
                out_dslot[j]                  = in_dslot[j % PUSH_N];
            end
        end
    end

endmodule
